udp_word_packer: RTL and testbench

UDP_WORD_PACKER -- requirements
Module: udp_word_packer

---
 rtl/udp_word_packer_pkg.sv | 14 +
 rtl/udp_word_packer_if.sv | 30 +++
 rtl/udp_sat_cnt.sv | 18 +
 rtl/udp_word_packer.sv | 102 ++++++++++
 tb/tb_udp_word_packer.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/udp_word_packer_pkg.sv
// Shared constants and helpers for the nibble-to-word packer.
// Default beat/word widths and the overflow counter width live here.
package udp_word_packer_pkg;

  localparam int DEF_IN_W  = 4;
  localparam int DEF_OUT_W = 16;
  localparam int OVF_W     = 16;

  // Physical lane slot for a logical lane (arrival order).
  function automatic int lane_pos(input int lane, input int r, input bit msb_first);
    return msb_first ? (r - 1 - lane) : lane;
  endfunction

endpackage

// File: rtl/udp_word_packer_if.sv
// Beat-in / word-out bus of the packer. The packer uses the slave view,
// the beat source / word sink uses the master view.
interface udp_word_packer_if
  import udp_word_packer_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W
);
  localparam int R = OUT_W / IN_W;

  logic [IN_W-1:0]  in_data;
  logic             in_en;
  logic             in_last;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_last;
  logic [R-1:0]     out_keep;

  modport master (
    output in_data, in_en, in_last, out_ready,
    input  out_data, out_valid, out_last, out_keep
  );

  modport slave (
    input  in_data, in_en, in_last, out_ready,
    output out_data, out_valid, out_last, out_keep
  );

endinterface

// File: rtl/udp_sat_cnt.sv
// Event counter that sticks at all-ones instead of wrapping.
module udp_sat_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + WIDTH'(1);
  end

endmodule

// File: rtl/udp_word_packer.sv
// Packs IN_W-bit beats into OUT_W-bit words with per-lane keep, frame-last
// marking and a one-deep output register; words completing into a stalled
// output are dropped and counted.
module udp_word_packer
  import udp_word_packer_pkg::*;
#(
  parameter int              IN_W      = DEF_IN_W,
  parameter int              OUT_W     = DEF_OUT_W,
  parameter bit              MSB_FIRST = 1'b0,
  parameter logic [IN_W-1:0] PAD       = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  udp_word_packer_if.slave bus,
  output logic [OVF_W-1:0] ovf_cnt
);

  localparam int R  = OUT_W / IN_W;
  localparam int CW = (R > 1) ? $clog2(R) : 1;

  if (OUT_W % IN_W != 0) begin : g_bad_ratio
    $error("udp_word_packer: OUT_W must be an integer multiple of IN_W");
  end
  if (R < 2 || R > 16) begin : g_bad_lanes
    $error("udp_word_packer: OUT_W/IN_W must lie in 2..16");
  end

  logic [CW-1:0]            cnt;
  logic [R-1:0][IN_W-1:0]   acc;
  logic [R-1:0][IN_W-1:0]   word_nxt;
  logic [R-1:0]             keep_nxt;
  logic [R-1:0][IN_W-1:0]   data_q;
  logic [R-1:0]             keep_q;
  logic                     valid_q;
  logic                     last_q;
  logic                     done;
  logic                     can_load;
  logic                     drop;

  assign done     = bus.in_en && (bus.in_last || (cnt == CW'(R - 1)));
  assign can_load = !valid_q || bus.out_ready;
  assign drop     = done && !can_load;

  // Lanes below cnt come from the accumulator, lane cnt is the live beat,
  // the rest are padding. Stale accumulator content above cnt never leaks.
  always_comb begin
    word_nxt = '0;
    keep_nxt = '0;
    for (int i = 0; i < R; i++) begin
      if (i < int'(cnt)) begin
        word_nxt[lane_pos(i, R, MSB_FIRST)] = acc[i];
        keep_nxt[lane_pos(i, R, MSB_FIRST)] = 1'b1;
      end else if (i == int'(cnt)) begin
        word_nxt[lane_pos(i, R, MSB_FIRST)] = bus.in_data;
        keep_nxt[lane_pos(i, R, MSB_FIRST)] = 1'b1;
      end else begin
        word_nxt[lane_pos(i, R, MSB_FIRST)] = PAD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      acc <= '0;
    end else if (bus.in_en) begin
      for (int i = 0; i < R; i++)
        if (i == int'(cnt)) acc[i] <= bus.in_data;
      // A dropped word still restarts the accumulator at lane 0.
      cnt <= done ? '0 : cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
    end else if (done && can_load) begin
      valid_q <= 1'b1;
      data_q  <= word_nxt;
      keep_q  <= keep_nxt;
      last_q  <= bus.in_last;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_keep  = keep_q;
  assign bus.out_valid = valid_q;
  assign bus.out_last  = last_q;

  udp_sat_cnt #(.WIDTH(OVF_W)) u_ovf (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (drop),
    .count (ovf_cnt)
  );

endmodule

// File: tb/tb_udp_word_packer.sv
// Randomized and directed bench for udp_word_packer: an LSB-first and an
// MSB-first instance share stimulus and are compared to a word-level model.
module tb_udp_word_packer;

  localparam int R = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  in_data = '0;
  logic        in_en = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] ovf0, ovf1;

  int checks = 0;
  int errors = 0;

  udp_word_packer_if #(.IN_W(4), .OUT_W(16)) bus0 ();
  udp_word_packer_if #(.IN_W(4), .OUT_W(16)) bus1 ();

  assign bus0.in_data = in_data;   assign bus1.in_data = in_data;
  assign bus0.in_en = in_en;       assign bus1.in_en = in_en;
  assign bus0.in_last = in_last;   assign bus1.in_last = in_last;
  assign bus0.out_ready = out_ready; assign bus1.out_ready = out_ready;

  udp_word_packer #(.IN_W(4), .OUT_W(16), .MSB_FIRST(1'b0), .PAD(4'h0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .ovf_cnt(ovf0));
  udp_word_packer #(.IN_W(4), .OUT_W(16), .MSB_FIRST(1'b1), .PAD(4'h0)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .ovf_cnt(ovf1));

  always #5 clk = ~clk;

  // Reference model: list of pending beats plus the held output word.
  logic [3:0]  beats[$];
  logic        m_valid, m_last;
  logic [15:0] m_data, m_data_m;
  logic [3:0]  m_keep, m_keep_m;
  int          m_ovf;
  logic [15:0] exp_words[$];
  logic [15:0] got[$];

  task automatic model_clear();
    beats.delete();
    m_valid = 1'b0; m_last = 1'b0;
    m_data = '0; m_data_m = '0; m_keep = '0; m_keep_m = '0;
    m_ovf = 0;
  endtask

  // Applies the model to the inputs present now, then advances one clock.
  task automatic tick();
    logic [15:0] w, wm;
    logic [3:0]  k, km;
    bit fire;
    if (rst_n) begin
      fire = m_valid && out_ready;
      if (in_en) begin
        beats.push_back(in_data);
        if (beats.size() == R || in_last) begin
          w = '0; wm = '0; k = '0; km = '0;
          foreach (beats[i]) begin
            w  = w  | (16'(beats[i]) << (4 * i));
            wm = wm | (16'(beats[i]) << (12 - 4 * i));
            k[i] = 1'b1;
            km[3 - i] = 1'b1;
          end
          if (!m_valid || out_ready) begin
            m_valid = 1'b1; m_data = w; m_data_m = wm;
            m_keep = k; m_keep_m = km; m_last = in_last;
            exp_words.push_back(w);
          end else if (m_ovf < 65535) begin
            m_ovf++;
          end
          beats.delete();
        end else if (fire) m_valid = 1'b0;
      end else if (fire) m_valid = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; model_clear();
    tick(); tick();
    checks++; if (bus0.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", bus0.out_valid); end
    checks++; if (bus0.out_data !== 16'h0) begin errors++; $display("FAIL reset_data: got %h want 0000", bus0.out_data); end
    checks++; if (bus0.out_keep !== 4'h0) begin errors++; $display("FAIL reset_keep: got %b want 0000", bus0.out_keep); end
    checks++; if (bus0.out_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %0b want 0", bus0.out_last); end
    checks++; if (ovf0 !== 16'h0) begin errors++; $display("FAIL reset_ovf: got %0d want 0", ovf0); end
    rst_n = 1'b1;
    tick();
    checks++; if (bus1.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid_msb: got %0b want 0", bus1.out_valid); end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_en = 1'b1; in_last = 1'b0; in_data = 4'(i);
      tick();
      if (i < 4) begin
        checks++; if (bus0.out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: beat %0d got %0b want 0", i, bus0.out_valid); end
      end
    end
    in_en = 1'b0;
    checks++; if (bus0.out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0b want 1", bus0.out_valid); end
    checks++; if (bus0.out_data !== 16'h4321) begin errors++; $display("FAIL basic_data: got %h want 4321", bus0.out_data); end
    checks++; if (bus0.out_keep !== 4'hF) begin errors++; $display("FAIL basic_keep: got %b want 1111", bus0.out_keep); end
    checks++; if (bus0.out_last !== 1'b0) begin errors++; $display("FAIL basic_last: got %0b want 0", bus0.out_last); end
    tick();
    checks++; if (bus0.out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: got %0b want 0", bus0.out_valid); end
  endtask

  task automatic test_msb_first();
    logic [3:0] seq [4];
    seq[0] = 4'hA; seq[1] = 4'hB; seq[2] = 4'hC; seq[3] = 4'hD;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_en = 1'b1; in_last = 1'b0; in_data = seq[i];
      tick();
    end
    in_en = 1'b0;
    checks++; if (bus1.out_data !== 16'hABCD) begin errors++; $display("FAIL msb_data: got %h want abcd", bus1.out_data); end
    checks++; if (bus0.out_data !== 16'hDCBA) begin errors++; $display("FAIL lsb_data: got %h want dcba", bus0.out_data); end
    checks++; if (bus1.out_keep !== 4'hF) begin errors++; $display("FAIL msb_keep: got %b want 1111", bus1.out_keep); end
    tick();
  endtask

  task automatic test_partial();
    out_ready = 1'b1;
    in_en = 1'b1; in_last = 1'b0; in_data = 4'h5; tick();
    in_last = 1'b1; in_data = 4'h6; tick();
    in_en = 1'b0; in_last = 1'b0;
    checks++; if (bus0.out_data !== 16'h0065) begin errors++; $display("FAIL partial_data: got %h want 0065", bus0.out_data); end
    checks++; if (bus0.out_keep !== 4'b0011) begin errors++; $display("FAIL partial_keep: got %b want 0011", bus0.out_keep); end
    checks++; if (bus0.out_last !== 1'b1) begin errors++; $display("FAIL partial_last: got %0b want 1", bus0.out_last); end
    checks++; if (bus1.out_data !== 16'h5600) begin errors++; $display("FAIL partial_msb_data: got %h want 5600", bus1.out_data); end
    checks++; if (bus1.out_keep !== 4'b1100) begin errors++; $display("FAIL partial_msb_keep: got %b want 1100", bus1.out_keep); end
    // in_last without in_en must be ignored
    in_last = 1'b1; tick(); in_last = 1'b0;
    for (int i = 7; i <= 10; i++) begin
      in_en = 1'b1; in_data = 4'(i); tick();
    end
    in_en = 1'b0;
    checks++; if (bus0.out_data !== 16'hA987) begin errors++; $display("FAIL partial_restart: got %h want a987", bus0.out_data); end
    checks++; if (bus0.out_last !== 1'b0) begin errors++; $display("FAIL partial_restart_last: got %0b want 0", bus0.out_last); end
    tick();
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      in_en = 1'b1; in_last = 1'b0; in_data = 4'(i);
      tick();
      if (i == 4) begin
        checks++; if (bus0.out_data !== 16'h4321) begin errors++; $display("FAIL ovf_first: got %h want 4321", bus0.out_data); end
      end
    end
    in_en = 1'b0;
    checks++; if (ovf0 !== 16'd1) begin errors++; $display("FAIL ovf_count: got %0d want 1", ovf0); end
    checks++; if (bus0.out_data !== 16'h4321) begin errors++; $display("FAIL ovf_held: got %h want 4321", bus0.out_data); end
    checks++; if (bus0.out_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid: got %0b want 1", bus0.out_valid); end
    out_ready = 1'b1;
    tick();
    checks++; if (bus0.out_valid !== 1'b0) begin errors++; $display("FAIL ovf_xfer: got %0b want 0", bus0.out_valid); end
  endtask

  task automatic test_back_to_back();
    int base;
    base = m_ovf;
    exp_words.delete(); got.delete();
    for (int c = 0; c < 48; c++) begin
      in_en = 1'b1; in_last = 1'b0; in_data = 4'($urandom);
      out_ready = c[0];
      if (bus0.out_valid && out_ready) got.push_back(bus0.out_data);
      tick();
    end
    in_en = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (bus0.out_valid && out_ready) got.push_back(bus0.out_data);
      tick();
    end
    checks++; if (got.size() != 12) begin errors++; $display("FAIL b2b_count: got %0d words want 12", got.size()); end
    checks++; if (exp_words.size() != 12) begin errors++; $display("FAIL b2b_model_count: model %0d words want 12", exp_words.size()); end
    for (int i = 0; i < 12 && i < got.size() && i < exp_words.size(); i++) begin
      checks++; if (got[i] !== exp_words[i]) begin errors++; $display("FAIL b2b_word%0d: got %h want %h", i, got[i], exp_words[i]); end
    end
    checks++; if (int'(ovf0) != base) begin errors++; $display("FAIL b2b_ovf: got %0d want %0d", ovf0, base); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      in_en = ($urandom_range(0, 3) != 0);
      in_data = 4'($urandom);
      in_last = ($urandom_range(0, 4) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
      checks++; if (bus0.out_valid !== m_valid) begin errors++; $display("FAIL rnd_valid c%0d: got %0b want %0b", c, bus0.out_valid, m_valid); end
      checks++; if (bus0.out_data !== m_data) begin errors++; $display("FAIL rnd_data c%0d: got %h want %h", c, bus0.out_data, m_data); end
      checks++; if (bus0.out_keep !== m_keep) begin errors++; $display("FAIL rnd_keep c%0d: got %b want %b", c, bus0.out_keep, m_keep); end
      checks++; if (bus0.out_last !== m_last) begin errors++; $display("FAIL rnd_last c%0d: got %0b want %0b", c, bus0.out_last, m_last); end
      checks++; if (bus1.out_data !== m_data_m) begin errors++; $display("FAIL rnd_msb_data c%0d: got %h want %h", c, bus1.out_data, m_data_m); end
      checks++; if (bus1.out_keep !== m_keep_m) begin errors++; $display("FAIL rnd_msb_keep c%0d: got %b want %b", c, bus1.out_keep, m_keep_m); end
      checks++; if (int'(ovf0) != m_ovf) begin errors++; $display("FAIL rnd_ovf c%0d: got %0d want %0d", c, ovf0, m_ovf); end
    end
    in_en = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    logic [3:0] seq [4];
    seq[0] = 4'h9; seq[1] = 4'hA; seq[2] = 4'hB; seq[3] = 4'hC;
    out_ready = 1'b1;
    in_en = 1'b1; in_last = 1'b0;
    in_data = 4'h1; tick();
    in_data = 4'h2; tick();
    rst_n = 1'b0; model_clear();
    #1;
    in_data = 4'hF; tick();
    checks++; if (bus0.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %0b want 0", bus0.out_valid); end
    checks++; if (bus0.out_data !== 16'h0) begin errors++; $display("FAIL rmid_data: got %h want 0000", bus0.out_data); end
    checks++; if (bus0.out_keep !== 4'h0) begin errors++; $display("FAIL rmid_keep: got %b want 0000", bus0.out_keep); end
    checks++; if (bus0.out_last !== 1'b0) begin errors++; $display("FAIL rmid_last: got %0b want 0", bus0.out_last); end
    checks++; if (ovf0 !== 16'h0) begin errors++; $display("FAIL rmid_ovf: got %0d want 0", ovf0); end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = seq[i]; tick();
    end
    in_en = 1'b0;
    checks++; if (bus0.out_data !== 16'hCBA9) begin errors++; $display("FAIL rmid_word: got %h want cba9", bus0.out_data); end
    checks++; if (bus0.out_keep !== 4'hF) begin errors++; $display("FAIL rmid_word_keep: got %b want 1111", bus0.out_keep); end
    tick();
  endtask

  initial begin
    model_clear();
    test_reset();
    test_basic();
    test_msb_first();
    test_partial();
    test_overflow();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
